// File: rtl/riscv_dtm.sv
// RISC-V Debug Transport Module: IDCODE, DTMCS and DMI data registers behind the
// JTAG TAP, plus a minimal Debug Module register file reached over DMI.
module riscv_dtm #(
    parameter logic [31:0] IDCODE = 32'h1DEAD3FF
) (
    input  logic       tck_i,
    input  logic       ntrst_i,
    input  logic       tdi_i,
    output logic       tdo_o,
    input  logic       capture_dr_i,
    input  logic       shift_dr_i,
    input  logic       update_dr_i,
    input  logic [4:0] ir_i
);

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_DTMCS  = 2'd2,
        SEL_DMI    = 2'd3
    } sel_e;

    localparam logic [31:0] DTMCS_VALUE = 32'h00001071;

    sel_e        sel_s;
    logic [40:0] sr_r;
    logic [40:0] sr_next_s;
    logic [6:0]  last_addr_r;
    logic [31:0] result_data_r;
    logic [31:0] data0_r;
    logic [31:0] data1_r;
    logic [31:0] progbuf0_r;
    logic [31:0] progbuf1_r;
    logic        haltreq_r;
    logic        ndmreset_r;
    logic        dmactive_r;
    logic        halted_r;

    logic        upd_s;
    logic        dmi_upd_s;
    logic        hard_reset_s;
    logic        dm_wr_s;
    logic        dm_rd_s;
    logic [6:0]  dmi_addr_s;
    logic [31:0] dmi_data_s;
    logic [1:0]  dmi_op_s;
    logic [31:0] dm_rdata_s;

    assign tdo_o      = sr_r[0];
    assign dmi_addr_s = sr_r[40:34];
    assign dmi_data_s = sr_r[33:2];
    assign dmi_op_s   = sr_r[1:0];

    // Update only acts when no higher-priority strobe is present in the same cycle.
    assign upd_s        = update_dr_i && !capture_dr_i && !shift_dr_i;
    assign dmi_upd_s    = upd_s && (sel_s == SEL_DMI);
    assign hard_reset_s = upd_s && (sel_s == SEL_DTMCS) && sr_r[17];
    assign dm_wr_s      = dmi_upd_s && (dmi_op_s == 2'd2);
    assign dm_rd_s      = dmi_upd_s && (dmi_op_s == 2'd1);

    // Instruction decode to data register select.
    always_comb begin
        sel_s = SEL_BYPASS;
        case (ir_i)
            5'b00001: sel_s = SEL_IDCODE;
            5'b10000: sel_s = SEL_DTMCS;
            5'b10001: sel_s = SEL_DMI;
            default:  sel_s = SEL_BYPASS;
        endcase
    end

    // DM register read mux; unmapped addresses read zero.
    always_comb begin
        dm_rdata_s = 32'h0000_0000;
        case (dmi_addr_s)
            7'h04:   dm_rdata_s = data0_r;
            7'h05:   dm_rdata_s = data1_r;
            7'h20:   dm_rdata_s = progbuf0_r;
            7'h21:   dm_rdata_s = progbuf1_r;
            7'h10:   dm_rdata_s = {haltreq_r, 29'h0, ndmreset_r, dmactive_r};
            7'h11:   dm_rdata_s = {20'h0, !halted_r, !halted_r, halted_r, halted_r,
                                   1'b1, 3'b000, 4'd2};
            default: dm_rdata_s = 32'h0000_0000;
        endcase
    end

    // Shift register next value: capture, then shift, over the selected width only.
    always_comb begin
        sr_next_s = sr_r;
        if (capture_dr_i) begin
            case (sel_s)
                SEL_IDCODE: sr_next_s[31:0] = IDCODE;
                SEL_DTMCS:  sr_next_s[31:0] = DTMCS_VALUE;
                SEL_DMI:    sr_next_s = {last_addr_r, result_data_r, 2'b00};
                default:    sr_next_s[0] = 1'b0;
            endcase
        end else if (shift_dr_i) begin
            case (sel_s)
                SEL_IDCODE: sr_next_s[31:0] = {tdi_i, sr_r[31:1]};
                SEL_DTMCS:  sr_next_s[31:0] = {tdi_i, sr_r[31:1]};
                SEL_DMI:    sr_next_s = {tdi_i, sr_r[40:1]};
                default:    sr_next_s[0] = tdi_i;
            endcase
        end else begin
            sr_next_s = sr_r;
        end
    end

    // Shift register state.
    always_ff @(posedge tck_i or negedge ntrst_i) begin
        if (!ntrst_i) begin
            sr_r <= 41'h0;
        end else begin
            sr_r <= sr_next_s;
        end
    end

    // DMI transaction bookkeeping: last address and returned data.
    always_ff @(posedge tck_i or negedge ntrst_i) begin
        if (!ntrst_i) begin
            last_addr_r   <= 7'h00;
            result_data_r <= 32'h0000_0000;
        end else if (hard_reset_s) begin
            last_addr_r   <= 7'h00;
            result_data_r <= 32'h0000_0000;
        end else if (dmi_upd_s) begin
            last_addr_r <= dmi_addr_s;
            if (dm_rd_s) begin
                result_data_r <= dm_rdata_s;
            end else if (dm_wr_s) begin
                result_data_r <= dmi_data_s;
            end else begin
                result_data_r <= result_data_r;
            end
        end else begin
            last_addr_r   <= last_addr_r;
            result_data_r <= result_data_r;
        end
    end

    // Debug Module register file and hart halted flag.
    always_ff @(posedge tck_i or negedge ntrst_i) begin
        if (!ntrst_i) begin
            data0_r    <= 32'h0;
            data1_r    <= 32'h0;
            progbuf0_r <= 32'h0;
            progbuf1_r <= 32'h0;
            haltreq_r  <= 1'b0;
            ndmreset_r <= 1'b0;
            dmactive_r <= 1'b0;
            halted_r   <= 1'b0;
        end else if (hard_reset_s) begin
            data0_r    <= 32'h0;
            data1_r    <= 32'h0;
            progbuf0_r <= 32'h0;
            progbuf1_r <= 32'h0;
            haltreq_r  <= 1'b0;
            ndmreset_r <= 1'b0;
            dmactive_r <= 1'b0;
            halted_r   <= 1'b0;
        end else if (dm_wr_s) begin
            case (dmi_addr_s)
                7'h04: data0_r    <= dmi_data_s;
                7'h05: data1_r    <= dmi_data_s;
                7'h20: progbuf0_r <= dmi_data_s;
                7'h21: progbuf1_r <= dmi_data_s;
                7'h10: begin
                    haltreq_r  <= dmi_data_s[31];
                    ndmreset_r <= dmi_data_s[1];
                    dmactive_r <= dmi_data_s[0];
                    // resumereq wins over a simultaneous haltreq
                    if (dmi_data_s[30]) begin
                        halted_r <= 1'b0;
                    end else if (dmi_data_s[31]) begin
                        halted_r <= 1'b1;
                    end else begin
                        halted_r <= halted_r;
                    end
                end
                default: data0_r <= data0_r;
            endcase
        end else begin
            halted_r <= halted_r;
        end
    end

endmodule

// File: tb/tb_riscv_dtm.sv
// Directed plus randomized DR scans of riscv_dtm, checked against a register-level
// model of the DTM and Debug Module kept in the bench.
module tb_riscv_dtm;

    logic       tck = 1'b0;
    logic       ntrst = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       capture = 1'b0;
    logic       shift = 1'b0;
    logic       update = 1'b0;
    logic [4:0] ir = 5'b00001;

    int total = 0;
    int bad = 0;

    riscv_dtm dut (
        .tck_i(tck), .ntrst_i(ntrst), .tdi_i(tdi), .tdo_o(tdo),
        .capture_dr_i(capture), .shift_dr_i(shift), .update_dr_i(update), .ir_i(ir)
    );

    always #5 tck = ~tck;

    // Reference model
    logic [31:0] m_mem [0:127];
    logic        m_haltreq, m_ndm, m_act, m_halted;
    logic [6:0]  m_last;
    logic [31:0] m_res;

    task automatic m_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 32'h0;
        m_haltreq = 1'b0; m_ndm = 1'b0; m_act = 1'b0; m_halted = 1'b0;
        m_last = 7'h0; m_res = 32'h0;
    endtask

    function automatic logic [31:0] m_read(input logic [6:0] a);
        case (a)
            7'h04, 7'h05, 7'h20, 7'h21: return m_mem[a];
            7'h10:   return {m_haltreq, 29'h0, m_ndm, m_act};
            7'h11:   return m_halted ? 32'h0000_0382 : 32'h0000_0C82;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        if (op == 2'd1) begin
            m_res = m_read(a);
        end else if (op == 2'd2) begin
            if (a == 7'h04 || a == 7'h05 || a == 7'h20 || a == 7'h21) m_mem[a] = d;
            if (a == 7'h10) begin
                m_haltreq = d[31]; m_ndm = d[1]; m_act = d[0];
                if (d[30]) m_halted = 1'b0;
                else if (d[31]) m_halted = 1'b1;
            end
            m_res = d;
        end
        m_last = a;
    endtask

    task automatic check(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture, shift width bits LSB-first, then update.
    task automatic scan(input int width, input logic [40:0] din, output logic [40:0] dout);
        logic [40:0] acc;
        acc = '0;
        @(negedge tck); capture = 1'b1;
        @(negedge tck); capture = 1'b0; shift = 1'b1;
        for (int i = 0; i < width; i++) begin
            tdi = din[i];
            #1 acc[i] = tdo;
            @(negedge tck);
        end
        shift = 1'b0; update = 1'b1;
        @(negedge tck); update = 1'b0;
        dout = acc;
    endtask

    task automatic dmi_scan(input string tag, input logic [6:0] a, input logic [31:0] d,
                            input logic [1:0] op, output logic [40:0] cap);
        scan(41, {a, d, op}, cap);
        check(tag, cap, {m_last, m_res, 2'b00});
        m_dmi(a, d, op);
    endtask

    initial begin
        logic [40:0] cap;
        logic [6:0]  a;
        logic [31:0] d;
        logic [1:0]  op;
        logic [6:0]  addrs [0:6];
        addrs = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h12, 7'h20, 7'h21};
        m_reset();

        repeat (2) @(negedge tck);
        #1 check("reset_tdo", {40'h0, tdo}, 41'h0);
        ntrst = 1'b1;

        ir = 5'b00001;
        scan(32, 41'h0, cap);
        check("idcode", cap, {9'h0, 32'h1DEAD3FF});
        ir = 5'b10000;
        scan(32, 41'h0, cap);
        check("dtmcs", cap, {9'h0, 32'h00001071});

        ir = 5'b10001;
        dmi_scan("dmi_first", 7'h04, 32'hDEADBEEF, 2'd2, cap);
        check("dmi_first_zero", cap, 41'h0);
        dmi_scan("dmi_wr_echo", 7'h04, 32'h0, 2'd1, cap);
        dmi_scan("dmi_rd_data0", 7'h00, 32'h0, 2'd0, cap);
        check("dmi_rd_const", cap, {7'h04, 32'hDEADBEEF, 2'b00});

        dmi_scan("halt_wr", 7'h10, 32'h80000001, 2'd2, cap);
        dmi_scan("halt_rd", 7'h11, 32'h0, 2'd1, cap);
        dmi_scan("halt_status", 7'h10, 32'h40000001, 2'd2, cap);
        check("halted_const", {9'h0, cap[33:2]}, {9'h0, 32'h00000382});
        dmi_scan("resume_echo", 7'h11, 32'h0, 2'd1, cap);
        dmi_scan("resume_status", 7'h10, 32'h0, 2'd1, cap);
        check("running_const", {9'h0, cap[33:2]}, {9'h0, 32'h00000C82});

        ir = 5'b11111;
        scan(3, 41'b101, cap);
        check("bypass_ones", cap, 41'b010);
        ir = 5'b00000;
        scan(3, 41'b101, cap);
        check("bypass_zeros", cap, 41'b010);

        // dmihardreset clears DM state and the DMI capture contents
        ir = 5'b10001;
        dmi_scan("pre_hard", 7'h05, 32'hA5A5_0F0F, 2'd2, cap);
        ir = 5'b10000;
        scan(32, 41'h20000, cap);
        m_reset();
        ir = 5'b10001;
        dmi_scan("post_hard", 7'h05, 32'h0, 2'd1, cap);
        dmi_scan("post_hard_data1", 7'h00, 32'h0, 2'd0, cap);

        for (int n = 0; n < 60; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : addrs[$urandom_range(0, 6)];
            d  = $urandom;
            op = 2'($urandom);
            if (d[30]) d[31] = 1'b0;
            dmi_scan("rand_dmi", a, d, op, cap);
        end

        // Reset in the middle of a DMI shift discards it
        dmi_scan("pre_rst", 7'h04, 32'h12345678, 2'd2, cap);
        @(negedge tck); capture = 1'b1;
        @(negedge tck); capture = 1'b0; shift = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tdi = 1'($urandom);
            @(negedge tck);
        end
        #2 ntrst = 1'b0;
        #1 check("rst_tdo", {40'h0, tdo}, 41'h0);
        shift = 1'b0;
        m_reset();
        @(negedge tck); update = 1'b1;
        @(negedge tck); update = 1'b0; ntrst = 1'b1;
        dmi_scan("rst_capture", 7'h04, 32'h0, 2'd1, cap);
        check("rst_capture_zero", cap, 41'h0);
        dmi_scan("rst_data0", 7'h00, 32'h0, 2'd0, cap);
        check("rst_data0_const", cap, {7'h04, 32'h0, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
